// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key synchronise/debounce, IDLE/RUN/PAUSE/LAP FSM, 100 Hz prescaler.
// Define STOPWATCH_LAP_EN to build the LAP state, the lap-key debouncer and the hold output.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 500000,
  parameter int DB_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_start_stop_n,
  input  logic       key_clear_n,
  input  logic       key_lap_n,
  input  logic       max_reached,
  output logic       tick,
  output logic       clear,
  output logic       hold,
  output logic       running,
  output logic [1:0] state
);

`ifdef STOPWATCH_LAP_EN
  localparam int NKEY = 3;
`else
  localparam int NKEY = 2;
`endif
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PSW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  // ---------------------------------------------------------------- key path
  logic [NKEY-1:0] key_raw;
  logic [NKEY-1:0] sync1, sync2, db_level, armed;
  logic [NKEY-1:0] accept, press;
  logic [DBW-1:0]  db_cnt [NKEY];

`ifdef STOPWATCH_LAP_EN
  assign key_raw = {key_lap_n, key_clear_n, key_start_stop_n};
`else
  logic unused_lap;
  assign unused_lap = key_lap_n;
  assign key_raw    = {key_clear_n, key_start_stop_n};
`endif

  // A key only produces presses once it has been seen released after reset,
  // so a button held through reset needs a release before it counts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    accept = '0;
    press  = '0;
    for (int k = 0; k < NKEY; k++) begin
      accept[k] = (sync2[k] != db_level[k]) && (db_cnt[k] == DBW'(DB_CYCLES - 1));
      press[k]  = accept[k] & db_level[k] & armed[k];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '1;
      armed    <= '0;
      // NOTE: db_cnt is a handful of flops, not a RAM, so it is reset like any other register.
      for (int k = 0; k < NKEY; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      armed <= armed | sync2;
      for (int k = 0; k < NKEY; k++) begin
        if (sync2[k] == db_level[k]) begin
          db_cnt[k] <= '0;
        end else if (accept[k]) begin
          db_cnt[k]   <= '0;
          db_level[k] <= sync2[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + DBW'(1);
        end
      end
    end
  end

  // Priority start_stop > clear > lap; lower-priority presses in the same cycle are dropped.
  logic go_start, go_clear;
  assign go_start = press[0];
  assign go_clear = press[1] & ~press[0];
`ifdef STOPWATCH_LAP_EN
  logic go_lap;
  assign go_lap = press[2] & ~press[1] & ~press[0];
`endif

  // --------------------------------------------------------------------- FSM
  state_t         state_q, state_n;
  logic           clear_next, tick_next, counting, psc_end;
  logic [PSW-1:0] psc;

  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
  assign psc_end  = (psc == PSW'(TICK_DIV - 1));

  always_comb begin
    state_n    = state_q;
    clear_next = 1'b0;
    tick_next  = counting & psc_end & ~max_reached;
    case (state_q)
      S_IDLE: begin
        if (go_start)      state_n = S_RUN;
        else if (go_clear) clear_next = 1'b1;
      end
      S_RUN: begin
        if (max_reached || go_start) state_n = S_PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (go_lap)             state_n = S_LAP;
`endif
      end
      S_PAUSE: begin
        if (go_start) begin
          if (!max_reached) state_n = S_RUN;
        end else if (go_clear) begin
          state_n    = S_IDLE;
          clear_next = 1'b1;
        end
      end
`ifdef STOPWATCH_LAP_EN
      S_LAP: begin
        if (max_reached || go_start) state_n = S_PAUSE;
        else if (go_lap)             state_n = S_RUN;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      psc     <= '0;
      tick    <= 1'b0;
      clear   <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_n;
      tick    <= tick_next;
      clear   <= clear_next;
      running <= (state_n == S_RUN) || (state_n == S_LAP);
      // RUN<->LAP keeps counting, so the tick phase survives a lap capture.
      if (!counting || psc_end) psc <= '0;
      else                      psc <= psc + PSW'(1);
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) hold <= 1'b0;
    else       hold <= (state_n == S_LAP);
  end
`else
  assign hold = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized keys,
// all compared every cycle against a window-based behavioural model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_LAP = 3;

  logic       clk = 1'b0;
  logic       reset, k_ss, k_cl, k_lap, max_r;
  logic       tick, clear, hold, running;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .key_start_stop_n(k_ss),
    .key_clear_n     (k_cl),
    .key_lap_n       (k_lap),
    .max_reached     (max_r),
    .tick            (tick),
    .clear           (clear),
    .hold            (hold),
    .running         (running),
    .state           (state)
  );

  // ------------------------------------------------------------------ model
  int        m_state, m_phase;
  bit        m_tick, m_clear, m_hold, m_running;
  bit        m_s1[3], m_s2[3], m_db[3], m_armed[3];
  bit [31:0] m_hist[3];
  int        m_hist_n[3];

  // Advance the model across one clock edge using the inputs currently applied.
  // A key level is accepted once the last DB synchronised samples all disagree with it.
  task automatic model_edge();
    bit raw[3];
    bit p[3];
    bit all_diff, pre_run, do_start, do_clear, do_lap;
    int nxt;
    raw[0] = k_ss; raw[1] = k_cl; raw[2] = k_lap;
    if (reset) begin
      m_state = ST_IDLE; m_phase = 0;
      m_tick = 0; m_clear = 0; m_hold = 0; m_running = 0;
      for (int k = 0; k < 3; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_db[k] = 1; m_armed[k] = 0;
        m_hist[k] = '0; m_hist_n[k] = 0;
      end
      return;
    end
    for (int k = 0; k < 3; k++) begin
      m_hist[k] = {m_hist[k][30:0], m_s2[k]};
      if (m_hist_n[k] < DB) m_hist_n[k]++;
      all_diff = (m_hist_n[k] >= DB);
      for (int i = 0; i < DB; i++) if (m_hist[k][i] == m_db[k]) all_diff = 0;
      p[k] = all_diff && m_db[k] && m_armed[k];
      if (all_diff) begin
        m_db[k] = !m_db[k];
        m_hist_n[k] = 0;
      end
      m_armed[k] = m_armed[k] | m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
    end
    do_start = p[0];
    do_clear = p[1] && !p[0];
    do_lap   = LAP_EN && p[2] && !p[0] && !p[1];

    pre_run = (m_state == ST_RUN) || (m_state == ST_LAP);
    m_tick  = pre_run && (m_phase == TD - 1) && !max_r;
    m_phase = pre_run ? (m_phase + 1) % TD : 0;

    m_clear = 0;
    nxt = m_state;
    case (m_state)
      ST_IDLE:  if (do_start) nxt = ST_RUN; else if (do_clear) m_clear = 1;
      ST_RUN:   if (max_r || do_start) nxt = ST_PAUSE; else if (do_lap) nxt = ST_LAP;
      ST_PAUSE: begin
        if (do_start) begin
          if (!max_r) nxt = ST_RUN;
        end else if (do_clear) begin
          nxt = ST_IDLE;
          m_clear = 1;
        end
      end
      ST_LAP:   if (max_r || do_start) nxt = ST_PAUSE; else if (do_lap) nxt = ST_RUN;
      default:  nxt = ST_IDLE;
    endcase
    m_state   = nxt;
    m_running = (nxt == ST_RUN) || (nxt == ST_LAP);
    m_hold    = (nxt == ST_LAP);
  endtask

  // ------------------------------------------------------------- utilities
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("cycle_outputs", 8'({tick, clear, hold, running, state}),
          8'({m_tick, m_clear, m_hold, m_running, 2'(m_state)}));
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  // Clean press of one key: state effect is visible 5 edges after going low.
  task automatic press_and_release(input int k);
    if (k == 0) k_ss = 0; else if (k == 1) k_cl = 0; else k_lap = 0;
    step_n(5);
    k_ss = 1; k_cl = 1; k_lap = 1;
    step_n(6);
  endtask

  int tick_cnt;

  initial begin
    reset = 1; k_ss = 1; k_cl = 1; k_lap = 1; max_r = 0;
    step_n(2);
    check("reset_outputs", 8'({tick, clear, hold, running, state}), 8'h00);
    reset = 0;
    step_n(4);

    // Bouncing start: low 2, high 1, then steady low.
    k_ss = 0; step_n(2);
    k_ss = 1; step();
    k_ss = 0;
    step_n(4);
    check("bounce_state_before", 8'(state), 8'h0);
    step();
    check("bounce_state_run", 8'(state), 8'h1);
    check("bounce_running", 8'(running), 8'h1);
    k_ss = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("first_ticks", 8'(tick), 8'((i % 4) == 0));
    end
    step_n(2);

    // Stop, ticks cease, then clear from PAUSE.
    k_ss = 0; step_n(5);
    check("stop_state_pause", 8'(state), 8'h2);
    k_ss = 1;
    tick_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      tick_cnt += int'(tick);
    end
    check("pause_no_ticks", 8'(tick_cnt), 8'h0);
    k_cl = 0; step_n(5);
    check("clear_pulse_high", 8'(clear), 8'h1);
    check("clear_state_idle", 8'(state), 8'h0);
    k_cl = 1; step();
    check("clear_pulse_low", 8'(clear), 8'h0);
    step_n(5);

    // Lap capture and release.
    press_and_release(0);
    k_lap = 0; step_n(5);
    if (LAP_EN) begin
      check("lap_state", 8'(state), 8'h3);
      check("lap_hold", 8'(hold), 8'h1);
    end else begin
      check("lap_ignored_state", 8'(state), 8'h1);
      check("lap_ignored_hold", 8'(hold), 8'h0);
    end
    k_lap = 1; step_n(6);
    k_lap = 0; step_n(5);
    check("lap_again_state", 8'(state), 8'h1);
    check("lap_again_hold", 8'(hold), 8'h0);
    k_lap = 1; step_n(6);

    // Start and clear together from PAUSE: start wins, clear is discarded.
    press_and_release(0);
    check("pause_before_dual", 8'(state), 8'h2);
    k_ss = 0; k_cl = 0; step_n(5);
    check("dual_state_run", 8'(state), 8'h1);
    check("dual_clear_low", 8'(clear), 8'h0);
    k_ss = 1; k_cl = 1; step_n(6);

    // Saturation at 99.99.
    max_r = 1; step();
    check("max_state_pause", 8'(state), 8'h2);
    check("max_no_tick", 8'(tick), 8'h0);
    k_ss = 0; step_n(5);
    check("max_start_blocked", 8'(state), 8'h2);
    k_ss = 1; step_n(6);
    k_cl = 0; step_n(5);
    check("max_clear_state", 8'(state), 8'h0);
    check("max_clear_pulse", 8'(clear), 8'h1);
    k_cl = 1; max_r = 0; step_n(6);

    // Reset mid-RUN (in LAP when built), with start held through reset.
    press_and_release(0);
    press_and_release(2);
    reset = 1; k_ss = 0; step();
    check("midrun_reset_outputs", 8'({tick, clear, hold, running, state}), 8'h00);
    step_n(2);
    reset = 0; step_n(15);
    check("held_key_ignored", 8'(state), 8'h0);
    k_ss = 1; step_n(8);
    k_ss = 0; step_n(5);
    check("press_after_release", 8'(state), 8'h1);
    k_ss = 1; step_n(6);

    // Randomized key activity, saturation and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) k_ss  = ~k_ss;
      if ($urandom_range(0, 15) == 0) k_cl  = ~k_cl;
      if ($urandom_range(0, 15) == 0) k_lap = ~k_lap;
      if ($urandom_range(0, 39) == 0) max_r = ~max_r;
      reset = ($urandom_range(0, 599) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
